// File: rtl/xge_pkt_tx_gen.sv
// Packet traffic generator for the xge_mac pkt_tx interface: bursts of fixed-length
// frames with a seed-derived payload, honouring pkt_tx_full and an inter-packet gap.
module xge_pkt_tx_gen #(
    parameter int IPG_CYCLES = 2,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 9600
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] pkt_len,
    input  logic [15:0] pkt_count,
    input  logic [31:0] seed,
    input  logic        pkt_tx_full,
    output logic [63:0] pkt_tx_data,
    output logic        pkt_tx_val,
    output logic        pkt_tx_sop,
    output logic        pkt_tx_eop,
    output logic [2:0]  pkt_tx_mod,
    output logic        busy,
    output logic        done,
    output logic [15:0] pkts_sent
);

    localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t state, state_nxt;

    logic [13:0]      words_r, words_nxt, k_r, k_nxt;
    logic [2:0]       lmod_r, lmod_nxt;
    logic [15:0]      count_r, count_nxt, p_r, p_nxt, sent_nxt;
    logic [31:0]      seed_r, seed_nxt;
    logic [GAP_W-1:0] gap_r, gap_nxt;
    logic             stop_pend, stop_nxt;

    logic [63:0] data_nxt;
    logic        val_nxt, sop_nxt, eop_nxt, busy_nxt, done_nxt;
    logic [2:0]  mod_nxt;

    logic [13:0] len_c, words_c;
    logic        issue, last;
    logic [31:0] cur_seed;
    logic [15:0] cur_p, cur_count, cur_sent;
    logic [13:0] cur_k, cur_words;
    logic [2:0]  cur_mod;

    function automatic logic [13:0] clamp_len(input logic [13:0] len);
        if (len < 14'(MIN_LEN)) return 14'(MIN_LEN);
        if (len > 14'(MAX_LEN)) return 14'(MAX_LEN);
        return len;
    endfunction

    assign len_c   = clamp_len(pkt_len);
    assign words_c = (len_c + 14'd7) >> 3;

    always_comb begin
        state_nxt = state;
        words_nxt = words_r;
        lmod_nxt  = lmod_r;
        count_nxt = count_r;
        seed_nxt  = seed_r;
        p_nxt     = p_r;
        k_nxt     = k_r;
        gap_nxt   = gap_r;
        sent_nxt  = pkts_sent;
        stop_nxt  = stop_pend | stop;
        data_nxt  = pkt_tx_data;
        val_nxt   = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        mod_nxt   = 3'd0;
        done_nxt  = 1'b0;
        issue     = 1'b0;
        last      = 1'b0;
        cur_seed  = seed_r;
        cur_p     = p_r;
        cur_k     = k_r;
        cur_words = words_r;
        cur_mod   = lmod_r;
        cur_count = count_r;
        cur_sent  = pkts_sent;

        case (state)
            IDLE: begin
                stop_nxt = 1'b0;
                if (start) begin
                    // The first word leaves straight from IDLE so sop follows start by one cycle.
                    state_nxt = SEND;
                    words_nxt = words_c;
                    lmod_nxt  = len_c[2:0];
                    count_nxt = pkt_count;
                    seed_nxt  = seed;
                    p_nxt     = 16'd0;
                    k_nxt     = 14'd0;
                    sent_nxt  = 16'd0;
                    cur_seed  = seed;
                    cur_p     = 16'd0;
                    cur_k     = 14'd0;
                    cur_words = words_c;
                    cur_mod   = len_c[2:0];
                    cur_count = pkt_count;
                    cur_sent  = 16'd0;
                    issue     = !pkt_tx_full;
                end
            end
            SEND: issue = !pkt_tx_full;
            GAP: begin
                if (gap_r == GAP_W'(IPG_CYCLES - 1)) begin
                    gap_nxt   = '0;
                    state_nxt = stop_nxt ? DONE : SEND;
                end else begin
                    gap_nxt = gap_r + 1'b1;
                end
            end
            DONE: begin
                stop_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (issue) begin
            last     = (cur_k == cur_words - 14'd1);
            val_nxt  = 1'b1;
            data_nxt = {cur_seed + 32'(cur_p), cur_p, 16'(cur_k)};
            sop_nxt  = (cur_k == 14'd0);
            eop_nxt  = last;
            mod_nxt  = last ? cur_mod : 3'd0;
            if (last) begin
                k_nxt    = 14'd0;
                p_nxt    = cur_p + 16'd1;
                sent_nxt = (cur_sent == 16'hFFFF) ? cur_sent : cur_sent + 16'd1;
                if (stop_nxt || (cur_count != 16'd0 && ({1'b0, cur_sent} + 17'd1 == {1'b0, cur_count})))
                    state_nxt = DONE;
                else if (IPG_CYCLES > 0)
                    state_nxt = GAP;
                else
                    state_nxt = SEND;
            end else begin
                k_nxt = cur_k + 14'd1;
            end
        end

        // busy stays up through the done cycle and drops together with it.
        busy_nxt = (state_nxt != IDLE) || (state == DONE);
    end

    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state       <= IDLE;
            words_r     <= '0;
            lmod_r      <= '0;
            count_r     <= '0;
            seed_r      <= '0;
            p_r         <= '0;
            k_r         <= '0;
            gap_r       <= '0;
            stop_pend   <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pkts_sent   <= '0;
        end else begin
            state       <= state_nxt;
            words_r     <= words_nxt;
            lmod_r      <= lmod_nxt;
            count_r     <= count_nxt;
            seed_r      <= seed_nxt;
            p_r         <= p_nxt;
            k_r         <= k_nxt;
            gap_r       <= gap_nxt;
            stop_pend   <= stop_nxt;
            pkt_tx_data <= data_nxt;
            pkt_tx_val  <= val_nxt;
            pkt_tx_sop  <= sop_nxt;
            pkt_tx_eop  <= eop_nxt;
            pkt_tx_mod  <= mod_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            pkts_sent   <= sent_nxt;
        end
    end

endmodule

// File: tb/tb_xge_pkt_tx_gen.sv
// Randomized bench for xge_pkt_tx_gen: every observed cycle is compared with a
// frame/word reference model built from the length, payload and timing rules.
module tb_xge_pkt_tx_gen;

    localparam int IPG = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [13:0] pkt_len;
    logic [15:0] pkt_count;
    logic [31:0] seed;
    logic        full;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    int n_chk = 0;
    int n_err = 0;

    xge_pkt_tx_gen #(.IPG_CYCLES(IPG), .MIN_LEN(60), .MAX_LEN(9600)) dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .start          (start),
        .stop           (stop),
        .pkt_len        (pkt_len),
        .pkt_count      (pkt_count),
        .seed           (seed),
        .pkt_tx_full    (full),
        .pkt_tx_data    (pkt_tx_data),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .busy           (busy),
        .done           (done),
        .pkts_sent      (pkts_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input logic [31:0] sd, input int f, input int k);
        logic [31:0] s;
        logic [15:0] pf;
        logic [15:0] kk;
        s  = sd + 32'(f);
        pf = 16'(f);
        kk = 16'(k);
        return {s, pf, kk};
    endfunction

    // bp_mode: 0 no back-pressure, 1 random, 2 five-cycle hold before frame 0 word 2.
    // stop_frame/stop_word: stop pulsed when that word is seen; with gap_stop, pulsed on that frame's eop.
    task automatic run_burst(input int len, input int count, input logic [31:0] sd, input int bp_mode,
                             input int stop_frame, input int stop_word, input bit gap_stop,
                             input bit start_stop);
        int L, W, md, frames_exp, f, k, eops, gap_left, done_cyc, bp_left, idle0, last_sop;
        bit prev_full, final_seen, finished, exp_val;
        logic [63:0] last_data;
        L = (len < 60) ? 60 : ((len > 9600) ? 9600 : len);
        W = (L + 7) / 8;
        md = L % 8;
        frames_exp = (count == 0) ? 32'h4000_0000 : count;
        f = 0; k = 0; eops = 0; gap_left = 0; done_cyc = -1; bp_left = 0; idle0 = 0; last_sop = -1;
        final_seen = 0; finished = 0;
        last_data = pkt_tx_data;
        pkt_len = 14'(len);
        pkt_count = 16'(count);
        seed = sd;
        start = 1'b1;
        stop = start_stop;
        full = (bp_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
        prev_full = full;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop = 1'b0;
            exp_val = !final_seen && gap_left == 0 && !prev_full;
            if (gap_left > 0) gap_left--;
            check("val", pkt_tx_val, exp_val);
            if (pkt_tx_val) begin
                check("data", pkt_tx_data, model_word(sd, f, k));
                check("sop", pkt_tx_sop, k == 0);
                check("eop", pkt_tx_eop, k == W - 1);
                check("mod", pkt_tx_mod, (k == W - 1) ? md : 0);
                if (k == 0 && bp_mode == 0) begin
                    if (last_sop >= 0) check("sop_spacing", c - last_sop, W + IPG);
                    last_sop = c;
                end
                last_data = pkt_tx_data;
                if (!gap_stop && f == stop_frame && k == stop_word) begin
                    stop = 1'b1;
                    frames_exp = f + 1;
                end
                if (bp_mode == 2 && f == 0 && k == 1) bp_left = 5;
                if (k == W - 1) begin
                    eops++;
                    f++;
                    k = 0;
                    if (gap_stop && stop_frame == f - 1) begin
                        stop = 1'b1;
                        frames_exp = f;
                    end
                    if (eops == frames_exp) begin
                        final_seen = 1;
                        done_cyc = c + 1 + (gap_stop ? IPG : 0);
                    end else begin
                        gap_left = IPG;
                    end
                end else begin
                    k++;
                end
            end else begin
                check("idle_ctl", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
                check("data_hold", pkt_tx_data, last_data);
                if (f == 0 && k > 0) idle0++;
            end
            check("done", done, c == done_cyc);
            check("busy", busy, done_cyc < 0 || c <= done_cyc);
            check("pkts_sent", pkts_sent, 16'(eops));
            if (done_cyc >= 0 && c > done_cyc) begin
                finished = 1;
                break;
            end
            // Inputs that must be ignored mid-burst
            if (!final_seen && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
                pkt_len = 14'($urandom);
                pkt_count = 16'($urandom);
                seed = $urandom;
            end
            if (bp_mode == 1) begin
                full = ($urandom_range(0, 3) == 0);
            end else if (bp_mode == 2) begin
                full = (bp_left > 0);
                if (bp_left > 0) bp_left--;
            end else begin
                full = 1'b0;
            end
            prev_full = full;
        end
        check("burst_finished", finished, 1);
        if (bp_mode == 2) check("bp_idle_cycles", idle0, 5);
        full = 1'b0;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        pkt_len = '0;
        pkt_count = '0;
        seed = '0;
        full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", pkt_tx_data, 0);
        check("rst_ctl", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done}, 0);
        check("rst_sent", pkts_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // stop in IDLE is ignored and must not leak into the next burst
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);
        @(negedge clk);

        run_burst(64, 1, 32'h0000_0010, 0, -1, -1, 0, 0);
        run_burst(65, 1, 32'h1111_2222, 0, -1, -1, 0, 0);
        run_burst(20, 1, 32'h3333_4444, 0, -1, -1, 0, 0);
        run_burst(16383, 1, 32'h5555_6666, 0, -1, -1, 0, 0);
        run_burst(64, 1, 32'h7777_8888, 2, -1, -1, 0, 0);
        run_burst(64, 3, 32'hABCD_0000, 0, -1, -1, 0, 0);
        run_burst(64, 0, 32'h0BAD_F00D, 0, 1, 4, 0, 0);
        run_burst(72, 0, 32'h2222_0000, 0, 0, -1, 1, 0);
        run_burst(61, 2, 32'h4444_0001, 0, -1, -1, 0, 1);
        run_burst(67, 3, 32'hFFFF_FFFF, 0, -1, -1, 0, 0);
        for (int i = 0; i < 6; i++)
            run_burst($urandom_range(0, 200), $urandom_range(1, 4), $urandom, 1, -1, -1, 0, 0);
        run_burst($urandom_range(60, 150), 0, $urandom, 1, $urandom_range(0, 2), $urandom_range(0, 6), 0, 0);

        // reset mid-frame, then a fresh burst with a new seed
        pkt_len = 14'd64;
        pkt_count = 16'd0;
        seed = 32'hA5A5_0000;
        full = 1'b0;
        start = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (pkt_tx_val && pkt_tx_data[15:0] == 16'd5) begin
                found = 1;
                break;
            end
        end
        check("reach_word5", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ctl", {pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done}, 0);
        check("midrst_data", pkt_tx_data, 0);
        check("midrst_sent", pkts_sent, 0);
        rst_n = 1'b1;
        run_burst(64, 1, 32'h1234_5678, 0, -1, -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/xge_pkt_tx_gen.md
# xge_pkt_tx_gen

Packet traffic generator feeding the `xge_mac` transmit packet interface (`pkt_tx_*`) in the 156.25 MHz core domain. It emits a programmable number of frames of a given byte length with a deterministic, seed-derived payload. It honours `pkt_tx_full` back-pressure and inserts a fixed inter-packet gap. Its output feeds the MAC directly, both in loopback benches and in on-chip self-test.

## Interface
- `IPG_CYCLES`, default 2: idle cycles inserted between consecutive frames (0 allowed).
- `MIN_LEN`, default 60: minimum frame length in bytes, excluding the CRC the MAC appends.
- `MAX_LEN`, default 9600: maximum frame length in bytes.
- `clk_156m25`, in, 1: core clock.
- `reset_156m25_n`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: single-cycle request to begin a burst. Sampled only in IDLE.
- `stop`, in, 1: single-cycle request to end the burst after the current frame completes.
- `pkt_len`, in, 14: frame length in bytes. Latched on accepted `start`.
- `pkt_count`, in, 16: number of frames to send. 0 means continuous until `stop`. Latched on accepted `start`.
- `seed`, in, 32: payload seed. Latched on accepted `start`.
- `pkt_tx_full`, in, 1: MAC TX FIFO full/almost-full.
- `pkt_tx_data`, out, 64: frame data word.
- `pkt_tx_val`, out, 1: word valid.
- `pkt_tx_sop`, out, 1: first word of a frame. Qualified by `pkt_tx_val`.
- `pkt_tx_eop`, out, 1: last word of a frame. Qualified by `pkt_tx_val`.
- `pkt_tx_mod`, out, 3: valid bytes in the eop word. 0 means all 8 bytes valid.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse on return to IDLE.
- `pkts_sent`, out, 16: frames completed in the current burst. Cleared on accepted `start`.

## Operation
- All outputs are registered.
- Reset values: `pkt_tx_data`=0, `pkt_tx_val`=0, `pkt_tx_sop`=0, `pkt_tx_eop`=0, `pkt_tx_mod`=0, `busy`=0, `done`=0, `pkts_sent`=0. State after reset is IDLE.
- Length handling:
  - Latched length L = clamp(`pkt_len`, `MIN_LEN`, `MAX_LEN`).
  - Words per frame W = ceil(L/8). Use a 14-bit value computed as (L+7)>>3.
  - eop `pkt_tx_mod` = L[2:0].
- Payload: word k (0-based) of frame p (0-based within the burst) is {(seed+p)[31:0], p[15:0], k[15:0]}. The additions are 32-bit, wrap-around. `sop`, `eop` and `mod` are the only framing signals.
- States:
  - IDLE: `start`=1 → latch inputs, clear `pkts_sent` and `p` → SEND.
  - SEND: one word is issued per cycle, only when allowed (see Timing). After the eop word issues:
    - `pkts_sent`++, `p`++.
    - If `stop` is pending, or `pkt_count`≠0 and `pkts_sent`+1 == `pkt_count` → DONE.
    - Else if `IPG_CYCLES`>0 → GAP.
    - Else → SEND, starting a new frame.
  - GAP: counts `IPG_CYCLES` cycles with `val`=0 → SEND.
  - DONE: one cycle with `done`=1 → IDLE.
- `stop` is captured into a sticky pending flag in any non-IDLE state and cleared on entering IDLE.
  - A frame is never truncated.
  - `stop` during GAP → DONE at the end of the gap, with no further frame.
- `start` is ignored outside IDLE. `stop` is ignored in IDLE.
- Simultaneous `start`+`stop` in IDLE: the burst starts, the stop is discarded.
- `pkts_sent` saturates at 16'hFFFF in continuous mode. `p` wraps.

## Timing
- Back-pressure: a word is issued in cycle N+1 only if `pkt_tx_full` sampled low at edge N. If `pkt_tx_full` is sampled high, the next cycle has `val`=0 and the same word is held for retry.
- The MAC's almost-full margin absorbs this one-cycle response.
- Latency: `start` accepted at edge N, `pkt_tx_full` low → sop word with `val`=1 in cycle N+1.
- A frame with W=1 cannot occur (`MIN_LEN`≥8). sop and eop are never set on the same word.
- Outside valid words, `pkt_tx_sop`, `pkt_tx_eop` and `pkt_tx_mod` are 0 and `pkt_tx_data` holds its last value.
- With no back-pressure, frame-to-frame spacing is exactly W+`IPG_CYCLES` cycles, sop to sop.
- `done` is asserted one cycle after the last eop word. `busy` falls in the same cycle `done` falls.
- Reset asserted mid-frame: all outputs return to their reset values at the next edge. No eop is generated. Burst state is lost.

## Test plan
- Single 64-byte frame: `pkt_len`=64, `pkt_count`=1, `seed`=0x10 → 8 words, sop on word 0, eop on word 7, `mod`=0; word 3 = 0x00000010_0000_0003; `done` pulses one cycle after eop; `pkts_sent`=1.
- Odd length: `pkt_len`=65 → 9 words, eop `mod`=1. `pkt_len`=20 → clamped to 60, giving 8 words with `mod`=4.
- Back-pressure: hold `pkt_tx_full`=1 for 5 cycles starting at word 2 → exactly 5 `val`=0 cycles, word 2 is re-issued unchanged, no word is lost or duplicated.
- Burst: `pkt_count`=3, L=64, `IPG_CYCLES`=2 → sop-to-sop spacing 10 cycles; frame 2 word 0 upper half = seed+2; `done` after the third eop.
- Stop: `pkt_count`=0, `stop` pulsed at word 4 of frame 1 → frame 1 completes through eop, no frame 2, `pkts_sent`=2.
- Reset mid-frame at word 5 → `val`=0 at the next edge and `busy`=0. A subsequent `start` produces frame 0 with payload based on the new seed.
